// File: rtl/tlb_maint_if.sv
// Maintenance-port bundle between the EX-stage privilege FSM / TLB array
// and the TLB maintenance sequencer.
interface tlb_maint_if #(
  parameter int IDX_W = 4
);
  logic             tlbsrch_valid, tlbrd_valid, tlbwr_valid, tlbfill_valid, invtlb_valid;
  logic             tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready;
  logic [4:0]       invtlb_op;
  logic [9:0]       invtlb_asid;
  logic [18:0]      invtlb_va;
  logic [IDX_W-1:0] csr_tlbidx_index;
  logic [9:0]       csr_asid;
  logic [18:0]      csr_tlbehi_vppn;
  logic             srch_we, srch_hit;
  logic [IDX_W-1:0] srch_index;
  logic             csr_rd_we;
  logic             tlb_rd_en;
  logic [IDX_W-1:0] tlb_rd_idx;
  logic             tlb_rd_e, tlb_rd_g, tlb_rd_ps;
  logic [9:0]       tlb_rd_asid;
  logic [18:0]      tlb_rd_vppn;
  logic             tlb_we;
  logic [IDX_W-1:0] tlb_w_idx;
  logic             tlb_w_inv;
  logic             tlb_busy;

  // Sequencer side
  modport slave (
    input  tlbsrch_valid, tlbrd_valid, tlbwr_valid, tlbfill_valid, invtlb_valid,
    input  invtlb_op, invtlb_asid, invtlb_va, csr_tlbidx_index, csr_asid, csr_tlbehi_vppn,
    input  tlb_rd_e, tlb_rd_g, tlb_rd_ps, tlb_rd_asid, tlb_rd_vppn,
    output tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready,
    output srch_we, srch_hit, srch_index, csr_rd_we, tlb_rd_en, tlb_rd_idx,
    output tlb_we, tlb_w_idx, tlb_w_inv, tlb_busy
  );

  // Requester / array side
  modport master (
    output tlbsrch_valid, tlbrd_valid, tlbwr_valid, tlbfill_valid, invtlb_valid,
    output invtlb_op, invtlb_asid, invtlb_va, csr_tlbidx_index, csr_asid, csr_tlbehi_vppn,
    output tlb_rd_e, tlb_rd_g, tlb_rd_ps, tlb_rd_asid, tlb_rd_vppn,
    input  tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready,
    input  srch_we, srch_hit, srch_index, csr_rd_we, tlb_rd_en, tlb_rd_idx,
    input  tlb_we, tlb_w_idx, tlb_w_inv, tlb_busy
  );
endinterface

// File: rtl/tlb_maint_seq.sv
// TLB maintenance sequencer: serialises TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
// against the array. Searches and invalidations walk one entry per cycle,
// comparing the entry read in the previous cycle. Outputs are decoded
// combinationally from the current state and walk counter.
module tlb_maint_seq #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  tlb_maint_if.slave  m_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SRCH    = 3'd1,
    S_RD      = 3'd2,
    S_RD_RESP = 3'd3,
    S_WR      = 3'd4,
    S_FILL    = 3'd5,
    S_INV     = 3'd6
  } state_t;

  localparam logic [IDX_W:0] K_LAST = (IDX_W+1)'(TLBNUM);

  state_t           state_q, state_d;
  logic [IDX_W:0]   k_q, k_d;
  logic [IDX_W-1:0] fill_ctr_q;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic [4:0]       inv_op_q, inv_op_d;
  logic [9:0]       inv_asid_q, inv_asid_d;
  logic [18:0]      inv_va_q, inv_va_d;

  logic [IDX_W-1:0] prev_idx_s;
  logic             srch_hit_s;
  logic             inv_sel_s;

  // VPPN compare; a 4 MB page ignores the low 9 VPPN bits
  function automatic logic vppn_eq(input logic ps, input logic [18:0] a, input logic [18:0] b);
    if (ps) vppn_eq = (a[18:9] == b[18:9]);
    else    vppn_eq = (a == b);
  endfunction

  // INVTLB selection of one entry given its flags and compare results
  function automatic logic inv_select(input logic [4:0] op, input logic e, input logic g,
                                      input logic asid_eq, input logic va_eq);
    case (op)
      5'd0, 5'd1: inv_select = e;
      5'd2:       inv_select = e & g;
      5'd3:       inv_select = e & ~g;
      5'd4:       inv_select = e & ~g & asid_eq;
      5'd5:       inv_select = e & ~g & asid_eq & va_eq;
      5'd6:       inv_select = e & (g | asid_eq) & va_eq;
      default:    inv_select = 1'b0;
    endcase
  endfunction

  // The entry whose data is on the read bus is the one requested last cycle
  assign prev_idx_s = k_q[IDX_W-1:0] - IDX_W'(1);
  assign srch_hit_s = m_if.tlb_rd_e
                    & (m_if.tlb_rd_g | (m_if.tlb_rd_asid == m_if.csr_asid))
                    & vppn_eq(m_if.tlb_rd_ps, m_if.tlb_rd_vppn, m_if.csr_tlbehi_vppn);
  assign inv_sel_s  = inv_select(inv_op_q, m_if.tlb_rd_e, m_if.tlb_rd_g,
                                 m_if.tlb_rd_asid == inv_asid_q,
                                 vppn_eq(m_if.tlb_rd_ps, m_if.tlb_rd_vppn, inv_va_q));

  // State, walk counter, free-running fill counter and captured INVTLB operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      fill_ctr_q <= '0;
      fill_idx_q <= '0;
      inv_op_q   <= 5'd0;
      inv_asid_q <= 10'd0;
      inv_va_q   <= 19'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      fill_ctr_q <= fill_ctr_q + IDX_W'(1);
      fill_idx_q <= fill_idx_d;
      inv_op_q   <= inv_op_d;
      inv_asid_q <= inv_asid_d;
      inv_va_q   <= inv_va_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    fill_idx_d = fill_idx_q;
    inv_op_d   = inv_op_q;
    inv_asid_d = inv_asid_q;
    inv_va_d   = inv_va_q;

    m_if.tlbsrch_ready = 1'b0;
    m_if.tlbrd_ready   = 1'b0;
    m_if.tlbwr_ready   = 1'b0;
    m_if.tlbfill_ready = 1'b0;
    m_if.invtlb_ready  = 1'b0;
    m_if.srch_we       = 1'b0;
    m_if.srch_hit      = 1'b0;
    m_if.srch_index    = '0;
    m_if.csr_rd_we     = 1'b0;
    m_if.tlb_rd_en     = 1'b0;
    m_if.tlb_rd_idx    = '0;
    m_if.tlb_we        = 1'b0;
    m_if.tlb_w_idx     = '0;
    m_if.tlb_w_inv     = 1'b0;
    m_if.tlb_busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (m_if.tlbsrch_valid) begin
          state_d = S_SRCH;
          k_d     = '0;
        end else if (m_if.tlbrd_valid) begin
          state_d = S_RD;
        end else if (m_if.tlbwr_valid) begin
          state_d = S_WR;
        end else if (m_if.tlbfill_valid) begin
          state_d    = S_FILL;
          fill_idx_d = fill_ctr_q;
        end else if (m_if.invtlb_valid) begin
          state_d    = S_INV;
          k_d        = '0;
          inv_op_d   = m_if.invtlb_op;
          inv_asid_d = m_if.invtlb_asid;
          inv_va_d   = m_if.invtlb_va;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SRCH: begin
        if (k_q < K_LAST) begin
          m_if.tlb_rd_en  = 1'b1;
          m_if.tlb_rd_idx = k_q[IDX_W-1:0];
        end else begin
          m_if.tlb_rd_en  = 1'b0;
        end
        // A hit ends the walk at once; the read issued this cycle is dropped
        if ((k_q != '0) && srch_hit_s) begin
          m_if.srch_we       = 1'b1;
          m_if.srch_hit      = 1'b1;
          m_if.srch_index    = prev_idx_s;
          m_if.tlbsrch_ready = 1'b1;
          state_d            = S_IDLE;
        end else if (k_q == K_LAST) begin
          m_if.srch_we       = 1'b1;
          m_if.tlbsrch_ready = 1'b1;
          state_d            = S_IDLE;
        end else begin
          k_d = k_q + (IDX_W+1)'(1);
        end
      end
      S_RD: begin
        m_if.tlb_rd_en  = 1'b1;
        m_if.tlb_rd_idx = m_if.csr_tlbidx_index;
        state_d         = S_RD_RESP;
      end
      S_RD_RESP: begin
        m_if.csr_rd_we   = 1'b1;
        m_if.tlbrd_ready = 1'b1;
        state_d          = S_IDLE;
      end
      S_WR: begin
        m_if.tlb_we      = 1'b1;
        m_if.tlb_w_idx   = m_if.csr_tlbidx_index;
        m_if.tlbwr_ready = 1'b1;
        state_d          = S_IDLE;
      end
      S_FILL: begin
        m_if.tlb_we        = 1'b1;
        m_if.tlb_w_idx     = fill_idx_q;
        m_if.tlbfill_ready = 1'b1;
        state_d            = S_IDLE;
      end
      S_INV: begin
        if (inv_op_q >= 5'd7) begin
          m_if.invtlb_ready = 1'b1;
          state_d           = S_IDLE;
        end else begin
          if (k_q < K_LAST) begin
            m_if.tlb_rd_en  = 1'b1;
            m_if.tlb_rd_idx = k_q[IDX_W-1:0];
          end else begin
            m_if.tlb_rd_en  = 1'b0;
          end
          // Clearing entry k-1 uses the write port, so it never collides with reading entry k
          if ((k_q != '0) && inv_sel_s) begin
            m_if.tlb_we    = 1'b1;
            m_if.tlb_w_inv = 1'b1;
            m_if.tlb_w_idx = prev_idx_s;
          end else begin
            m_if.tlb_we    = 1'b0;
          end
          if (k_q == K_LAST) begin
            m_if.invtlb_ready = 1'b1;
            state_d           = S_IDLE;
          end else begin
            k_d = k_q + (IDX_W+1)'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tlb_maint_seq.sv
// Self-checking bench for tlb_maint_seq: the bench plays the TLB array and
// predicts every result from a plain scan of its own entry table.
module tb_tlb_maint_seq;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlb_maint_if #(.IDX_W(4)) bus();
  tlb_maint_seq #(.TLBNUM(16), .IDX_W(4)) dut (.clk(clk), .rst(rst), .m_if(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- TLB array model ----------------
  logic        m_e [N];
  logic        m_g [N];
  logic        m_ps[N];
  logic [9:0]  m_asid[N];
  logic [18:0] m_vppn[N];
  logic        ld_en = 1'b0;
  int          ld_idx = 0;
  logic        ld_e, ld_g, ld_ps;
  logic [9:0]  ld_asid;
  logic [18:0] ld_vppn;

  // Array: registered read data, invalidate/write port, bench back-door loads
  always @(posedge clk) begin
    if (bus.tlb_rd_en) begin
      bus.tlb_rd_e    <= m_e[bus.tlb_rd_idx];
      bus.tlb_rd_g    <= m_g[bus.tlb_rd_idx];
      bus.tlb_rd_ps   <= m_ps[bus.tlb_rd_idx];
      bus.tlb_rd_asid <= m_asid[bus.tlb_rd_idx];
      bus.tlb_rd_vppn <= m_vppn[bus.tlb_rd_idx];
    end
    if (bus.tlb_we) begin
      if (bus.tlb_w_inv) m_e[bus.tlb_w_idx] <= 1'b0;
      else begin
        m_e[bus.tlb_w_idx]    <= 1'b1;
        m_g[bus.tlb_w_idx]    <= 1'b0;
        m_ps[bus.tlb_w_idx]   <= 1'b0;
        m_asid[bus.tlb_w_idx] <= 10'h2AA;
        m_vppn[bus.tlb_w_idx] <= 19'h5A5A5;
      end
    end else if (ld_en) begin
      m_e[ld_idx]    <= ld_e;
      m_g[ld_idx]    <= ld_g;
      m_ps[ld_idx]   <= ld_ps;
      m_asid[ld_idx] <= ld_asid;
      m_vppn[ld_idx] <= ld_vppn;
    end
  end

  // Cycles since reset release: the fill counter value is this modulo N
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- reference rules ----------------
  function automatic bit va_eq(input int j, input logic [18:0] v);
    if (m_ps[j]) return m_vppn[j][18:9] == v[18:9];
    return m_vppn[j] == v;
  endfunction

  function automatic bit m_match(input int j, input logic [9:0] a, input logic [18:0] v);
    return m_e[j] && (m_g[j] || m_asid[j] == a) && va_eq(j, v);
  endfunction

  function automatic bit m_inv(input int j, input int op, input logic [9:0] a, input logic [18:0] v);
    bit am = (m_asid[j] == a);
    case (op)
      0, 1:    return m_e[j];
      2:       return m_e[j] && m_g[j];
      3:       return m_e[j] && !m_g[j];
      4:       return m_e[j] && !m_g[j] && am;
      5:       return m_e[j] && !m_g[j] && am && va_eq(j, v);
      6:       return m_e[j] && (m_g[j] || am) && va_eq(j, v);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] e_vec();
    logic [15:0] r;
    for (int i = 0; i < N; i++) r[i] = m_e[i];
    return r;
  endfunction

  function automatic logic [4:0] rdy_vec();
    return {bus.invtlb_ready, bus.tlbfill_ready, bus.tlbwr_ready, bus.tlbrd_ready, bus.tlbsrch_ready};
  endfunction

  function automatic logic [31:0] out_vec();
    return {8'h00, rdy_vec(), bus.srch_we, bus.srch_hit, bus.srch_index, bus.csr_rd_we,
            bus.tlb_rd_en, bus.tlb_rd_idx, bus.tlb_we, bus.tlb_w_idx, bus.tlb_w_inv, bus.tlb_busy};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_valid(input logic [4:0] v);
    bus.tlbsrch_valid = v[0];
    bus.tlbrd_valid   = v[1];
    bus.tlbwr_valid   = v[2];
    bus.tlbfill_valid = v[3];
    bus.invtlb_valid  = v[4];
  endtask

  task automatic load_ent(input int j, input logic e, input logic g, input logic ps,
                          input logic [9:0] a, input logic [18:0] v);
    ld_en = 1'b1; ld_idx = j; ld_e = e; ld_g = g; ld_ps = ps; ld_asid = a; ld_vppn = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) load_ent(i, 1'b0, 1'b0, 1'b0, 10'd0, 19'd0);
  endtask

  // Observations of the last operation
  logic [4:0]  o_rdy;
  int          o_lat, o_badt, o_wrn, o_wridx, o_rdlat, o_rdidx, o_csrlat, o_busybad, o_sidx;
  logic [15:0] o_rdmask, o_invmask;
  logic        o_swe, o_shit;

  // Drive a request in the current cycle, watch until a ready pulse, then check quiet idle
  task automatic run_op(input logic [4:0] req, input logic [4:0] exp_rdy, input int exp_lat,
                        input int inj_lat, input logic [4:0] inj);
    int quiet_bad = 0;
    o_rdy = 5'b0; o_lat = -1; o_badt = 0; o_wrn = 0; o_wridx = -1; o_rdlat = -1;
    o_rdidx = -1; o_csrlat = -1; o_busybad = 0; o_sidx = -1; o_swe = 1'b0; o_shit = 1'b0;
    o_rdmask = 16'h0; o_invmask = 16'h0;
    set_valid(req);
    for (int L = 1; L <= 40; L++) begin
      @(negedge clk);
      set_valid((L == inj_lat) ? inj : 5'b0);
      if (!bus.tlb_busy) o_busybad++;
      if (bus.tlb_rd_en) begin
        o_rdmask[bus.tlb_rd_idx] = 1'b1;
        if (o_rdlat < 0) begin o_rdlat = L; o_rdidx = int'(bus.tlb_rd_idx); end
      end
      if (bus.tlb_we) begin
        if (bus.tlb_w_inv) begin
          o_invmask[bus.tlb_w_idx] = 1'b1;
          if (int'(bus.tlb_w_idx) != L - 2) o_badt++;
        end else begin
          o_wrn++;
          o_wridx = int'(bus.tlb_w_idx);
        end
      end
      if (bus.csr_rd_we && o_csrlat < 0) o_csrlat = L;
      if (rdy_vec() != 5'b0) begin
        o_rdy = rdy_vec(); o_lat = L;
        o_swe = bus.srch_we; o_shit = bus.srch_hit; o_sidx = int'(bus.srch_index);
        break;
      end
    end
    chk("ready_channel", 32'(o_rdy), 32'(exp_rdy));
    chk("ready_latency", o_lat, exp_lat);
    chk("busy_while_active", o_busybad, 0);
    for (int q = 0; q < 3; q++) begin
      @(negedge clk);
      if (rdy_vec() != 5'b0 || bus.tlb_we || bus.tlb_busy || bus.tlb_rd_en) quiet_bad++;
    end
    chk("idle_after_ready", quiet_bad, 0);
  endtask

  task automatic do_srch(input logic [9:0] a, input logic [18:0] v, input int inj_lat, input logic [4:0] inj);
    int j = -1;
    int last;
    logic [15:0] em = 16'h0;
    for (int i = 0; i < N; i++) if (j < 0 && m_match(i, a, v)) j = i;
    last = (j < 0 || j + 1 > 15) ? 15 : j + 1;
    for (int i = 0; i <= last; i++) em[i] = 1'b1;
    bus.csr_asid = a; bus.csr_tlbehi_vppn = v;
    run_op(5'b00001, 5'b00001, (j < 0) ? 17 : j + 2, inj_lat, inj);
    chk("srch_we", 32'(o_swe), 32'd1);
    chk("srch_hit", 32'(o_shit), (j >= 0) ? 32'd1 : 32'd0);
    chk("srch_index", o_sidx, (j < 0) ? 0 : j);
    chk("srch_reads", 32'(o_rdmask), 32'(em));
    chk("srch_no_writes", o_wrn + $countones(o_invmask), 0);
  endtask

  task automatic do_inv(input int op, input logic [9:0] a, input logic [18:0] v);
    logic [15:0] em = 16'h0;
    logic [15:0] snap = e_vec();
    for (int i = 0; i < N; i++) em[i] = m_inv(i, op, a, v);
    bus.invtlb_op = 5'(op); bus.invtlb_asid = a; bus.invtlb_va = v;
    run_op(5'b10000, 5'b10000, (op >= 7) ? 1 : 17, 0, 5'b0);
    chk("inv_cleared_set", 32'(o_invmask), 32'(em));
    chk("inv_write_timing", o_badt, 0);
    chk("inv_reads", 32'(o_rdmask), (op >= 7) ? 32'h0 : 32'hFFFF);
    chk("inv_array_after", 32'(e_vec()), 32'(snap & ~em));
    chk("inv_no_entry_write", o_wrn, 0);
  endtask

  task automatic do_rd(input int idx);
    bus.csr_tlbidx_index = 4'(idx);
    run_op(5'b00010, 5'b00010, 2, 0, 5'b0);
    chk("rd_en_latency", o_rdlat, 1);
    chk("rd_index", o_rdidx, idx);
    chk("rd_reads", 32'(o_rdmask), 32'(16'h1 << idx));
    chk("csr_rd_we_latency", o_csrlat, 2);
  endtask

  task automatic do_fill();
    int exp_idx = cyc % N;
    run_op(5'b01000, 5'b01000, 1, 0, 5'b0);
    chk("fill_w_idx", o_wridx, exp_idx);
    chk("fill_one_write", o_wrn, 1);
  endtask

  task automatic rand_entries();
    for (int i = 0; i < N; i++)
      load_ent(i, ($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
               10'($urandom_range(0, 3)),
               {10'($urandom_range(0, 2)), 9'($urandom_range(0, 2))});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    set_valid(5'b0);
    bus.invtlb_op = 5'd0; bus.invtlb_asid = 10'd0; bus.invtlb_va = 19'd0;
    bus.csr_tlbidx_index = 4'd0; bus.csr_asid = 10'd0; bus.csr_tlbehi_vppn = 19'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", out_vec(), 32'h0);
    rst = 1'b0;
    clear_all();

    // Search: entries 3 and 9 match with ASID 5, lowest index wins
    load_ent(1, 1'b1, 1'b0, 1'b0, 10'd6, 19'h01000);
    load_ent(3, 1'b1, 1'b0, 1'b0, 10'd5, 19'h01000);
    load_ent(9, 1'b1, 1'b0, 1'b0, 10'd5, 19'h01000);
    do_srch(10'd5, 19'h01000, 0, 5'b0);

    // Search an empty TLB; a TLBWR pulse arriving mid-walk is dropped
    clear_all();
    do_srch(10'd5, 19'h01000, 3, 5'b00100);
    chk("dropped_wr_no_write", o_wrn, 0);

    // 4 MB page compares only the upper VPPN bits
    load_ent(7, 1'b1, 1'b1, 1'b1, 10'd1, 19'h12A00);
    do_srch(10'd2, 19'h12BFF, 0, 5'b0);
    load_ent(7, 1'b1, 1'b1, 1'b0, 10'd1, 19'h12A00);
    do_srch(10'd2, 19'h12BFF, 0, 5'b0);

    // INVTLB op 5 clears only the non-global ASID-matching entry
    clear_all();
    load_ent(2, 1'b1, 1'b0, 1'b0, 10'd3, 19'h00040);
    load_ent(4, 1'b1, 1'b1, 1'b0, 10'd3, 19'h00040);
    load_ent(6, 1'b1, 1'b0, 1'b0, 10'd4, 19'h00040);
    do_inv(5, 10'd3, 19'h00040);
    do_inv(9, 10'd3, 19'h00040);

    // TLBFILL at fill counter 15, then a fill after the wrap
    while ((cyc % N) != 15) @(negedge clk);
    do_fill();
    do_fill();

    // TLBWR and TLBFILL together: write wins, fill is dropped
    bus.csr_tlbidx_index = 4'd4;
    run_op(5'b01100, 5'b00100, 1, 0, 5'b0);
    chk("wr_w_idx", o_wridx, 4);
    chk("wr_one_write", o_wrn, 1);
    chk("wr_entry_written", 32'(m_asid[4]), 32'h2AA);
    do_rd(11);

    // Reset during an INVTLB walk at k=8: abandon, keep partial clears
    for (int i = 0; i < N; i++) load_ent(i, 1'b1, 1'b0, 1'b0, 10'd1, 19'd1);
    bus.invtlb_op = 5'd0;
    set_valid(5'b10000);
    for (int L = 1; L <= 9; L++) begin
      @(negedge clk);
      set_valid(5'b0);
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_inv_outputs", out_vec(), 32'h0);
    @(negedge clk);
    chk("rst_mid_inv_no_ready", 32'(rdy_vec()), 32'h0);
    rst = 1'b0;
    chk("rst_partial_clears", 32'(e_vec()), 32'hFF80);
    do_rd(5);

    // Randomized operations against the reference rules
    for (int it = 0; it < 30; it++) begin
      int kind = $urandom_range(0, 4);
      int r = $urandom_range(0, 15);
      logic [9:0]  a;
      logic [18:0] v;
      rand_entries();
      a = ($urandom % 4 == 0) ? 10'($urandom_range(0, 3)) : m_asid[r];
      v = ($urandom % 4 == 0) ? (m_vppn[r] ^ 19'h00001) : m_vppn[r];
      case (kind)
        0: do_srch(a, v, 0, 5'b0);
        1: do_rd($urandom_range(0, 15));
        2: begin
          bus.csr_tlbidx_index = 4'(r);
          run_op(5'b00100, 5'b00100, 1, 0, 5'b0);
          chk("rand_wr_idx", o_wridx, r);
        end
        3: do_fill();
        default: do_inv($urandom_range(0, 8), a, v);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
